// File: rtl/fifo_param.sv
// fifo_param - parametrised synchronous FIFO with occupancy count,
// programmable almost-full/almost-empty thresholds, concurrent read+write
// and sticky overflow/underflow error flags.
//
// Compile-time option: define FIFO_BTN_EDGE_EN to condition wr/rd as raw
// push-button inputs (2-flop synchroniser + release-edge detect). Without it,
// wr/rd are used directly as per-cycle request strobes.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   wr, rd       write / read request
//   in           write data, sampled on an accepted write
//   clr_err      synchronous clear of overflow/underflow
//   out          registered read data, valid the cycle after an accepted read
//   empty, full  occupancy == 0 / == 2**AW
//   almost_full  count >= AF_LVL
//   almost_empty count <= AE_LVL
//   count        occupancy, 0..2**AW
//   overflow     sticky: a write was rejected
//   underflow    sticky: a read was rejected
module fifo_param #(
  parameter int unsigned DW     = 8,
  parameter int unsigned AW     = 2,
  parameter int unsigned AF_LVL = 3,
  parameter int unsigned AE_LVL = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr,
  input  logic          rd,
  input  logic [DW-1:0] in,
  input  logic          clr_err,
  output logic [DW-1:0] out,
  output logic          empty,
  output logic          full,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          underflow
);

  localparam int unsigned DEPTH   = 2 ** AW;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_C    = (AW+1)'(AF_LVL);
  localparam logic [AW:0] AE_C    = (AW+1)'(AE_LVL);
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wrp, rdp;
  logic          wreq, rreq, wacc, racc;
  logic [AW:0]   count_nxt;

`ifdef FIFO_BTN_EDGE_EN
  logic wr_s1, wr_s2, rd_s1, rd_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_s1 <= 1'b0;
      wr_s2 <= 1'b0;
      rd_s1 <= 1'b0;
      rd_s2 <= 1'b0;
    end else begin
      wr_s1 <= wr;
      wr_s2 <= wr_s1;
      rd_s1 <= rd;
      rd_s2 <= rd_s1;
    end
  end

  // One-cycle pulse on button release: older sample high, newer sample low.
  assign wreq = ~wr_s1 & wr_s2;
  assign rreq = ~rd_s1 & rd_s2;
`else
  assign wreq = wr;
  assign rreq = rd;
`endif

  // A write while full is only accepted when a read frees the slot in the
  // same cycle; no write-to-read bypass when empty.
  assign wacc = wreq & (~full | rreq);
  assign racc = rreq & ~empty;

  always_comb begin
    count_nxt = count;
    if (wacc && !racc)
      count_nxt = count + CNT_ONE;
    else if (racc && !wacc)
      count_nxt = count - CNT_ONE;
  end

  // Storage is intentionally left out of reset.
  always_ff @(posedge clk) begin
    if (wacc)
      mem[wrp] <= in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrp          <= '0;
      rdp          <= '0;
      count        <= '0;
      out          <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= (AF_C == '0);
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wacc)
        wrp <= wrp + PTR_ONE;
      if (racc) begin
        rdp <= rdp + PTR_ONE;
        out <= mem[rdp];
      end

      // Flags come from the next count so they line up with count itself.
      count        <= count_nxt;
      empty        <= (count_nxt == '0);
      full         <= (count_nxt == DEPTH_C);
      almost_full  <= (count_nxt >= AF_C);
      almost_empty <= (count_nxt <= AE_C);

      // A new error in the same cycle wins over clr_err.
      if (wreq && !wacc)
        overflow <= 1'b1;
      else if (clr_err)
        overflow <= 1'b0;

      if (rreq && !racc)
        underflow <= 1'b1;
      else if (clr_err)
        underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_param.sv
module tb_fifo_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr, rd, clr_err;
  logic [7:0] in;
  logic [7:0] out;
  logic       empty, full, almost_full, almost_empty;
  logic [2:0] count;
  logic       overflow, underflow;

  int checks   = 0;
  int failures = 0;

  // Scoreboard: data pushed when a write is driven, popped when its read is driven.
  logic [7:0] sb[$];
  int         m_cnt;
  logic [7:0] m_out;

  fifo_param #(.DW(8), .AW(2), .AF_LVL(3), .AE_LVL(1)) dut (
    .clk(clk), .rst(rst), .wr(wr), .rd(rd), .in(in), .clr_err(clr_err),
    .out(out), .empty(empty), .full(full), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    sb.delete();
    m_cnt = 0;
    m_out = 8'h00;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr = 1'b0; rd = 1'b0; clr_err = 1'b0; in = 8'h00;
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({out, count} !== 11'h000) begin
      failures++;
      $display("FAIL reset_out_count: got out=%h count=%0d, expected out=00 count=0", out, count);
    end
    checks++;
    if ({empty, full, almost_empty, almost_full} !== 4'b1010) begin
      failures++;
      $display("FAIL reset_flags: got e/f/ae/af=%b, expected 1010", {empty, full, almost_empty, almost_full});
    end
    checks++;
    if ({overflow, underflow} !== 2'b00) begin
      failures++;
      $display("FAIL reset_err: got ovf/unf=%b, expected 00", {overflow, underflow});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

`ifndef FIFO_BTN_EDGE_EN
  // Drives one clock of strobes starting at a negedge and returns at the next
  // negedge, with the scoreboard updated for what should have been accepted.
  task automatic cycle(input logic w, input logic r, input logic [7:0] d, input logic c);
    logic wa, ra;
    wr = w; rd = r; in = d; clr_err = c;
    ra = r && (m_cnt > 0);
    wa = w && ((m_cnt < 4) || r);
    if (ra) m_out = sb.pop_front();
    if (wa) sb.push_back(d);
    m_cnt = m_cnt + (wa ? 1 : 0) - (ra ? 1 : 0);
    @(posedge clk);
    #1;
    wr = 1'b0; rd = 1'b0; clr_err = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b1, 1'b0, 8'(i * 17), 1'b0);
      checks++;
      if (count !== 3'(i)) begin
        failures++;
        $display("FAIL fill_count[%0d]: got %0d, expected %0d", i, count, i);
      end
      checks++;
      if ({almost_empty, almost_full, full, overflow} !== {i <= 1, i >= 3, i == 4, 1'b0}) begin
        failures++;
        $display("FAIL fill_flags[%0d]: got ae/af/f/ovf=%b, expected %b", i,
                 {almost_empty, almost_full, full, overflow}, {i <= 1, i >= 3, i == 4, 1'b0});
      end
    end
  endtask

  task automatic test_overflow_drain();
    logic [7:0] exp_data [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    cycle(1'b1, 1'b0, 8'h55, 1'b0);
    checks++;
    if ({overflow, count, full} !== {1'b1, 3'd4, 1'b1}) begin
      failures++;
      $display("FAIL ovf_write: got ovf=%b count=%0d full=%b, expected ovf=1 count=4 full=1", overflow, count, full);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 8'h00, 1'b0);
      checks++;
      if (out !== m_out || out !== exp_data[i]) begin
        failures++;
        $display("FAIL drain_out[%0d]: got %h, expected %h", i, out, exp_data[i]);
      end
      if (i == 0) begin
        cycle(1'b0, 1'b0, 8'hEE, 1'b0);
        checks++;
        if (out !== exp_data[0]) begin
          failures++;
          $display("FAIL out_hold: got %h, expected %h", out, exp_data[0]);
        end
      end
    end
    checks++;
    if ({empty, count} !== {1'b1, 3'd0}) begin
      failures++;
      $display("FAIL drain_empty: got empty=%b count=%0d, expected 1 0", empty, count);
    end
  endtask

  task automatic test_underflow();
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clear: got %b, expected 0", overflow);
    end
    cycle(1'b1, 1'b1, 8'h5A, 1'b0);
    checks++;
    if ({count, underflow, out} !== {3'd1, 1'b1, 8'h44}) begin
      failures++;
      $display("FAIL empty_wr_rd: got count=%0d unf=%b out=%h, expected 1 1 44", count, underflow, out);
    end
    cycle(1'b0, 1'b1, 8'h00, 1'b0);
    checks++;
    if (out !== m_out || out !== 8'h5A) begin
      failures++;
      $display("FAIL read_5a: got %h, expected 5a", out);
    end
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    checks++;
    if ({underflow, empty} !== 2'b01) begin
      failures++;
      $display("FAIL unf_clear: got unf=%b empty=%b, expected 0 1", underflow, empty);
    end
  endtask

  task automatic test_full_concurrent();
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 1'b0, 8'hA0 + 8'(i), 1'b0);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b1, 8'h99, 1'b0);
      checks++;
      if ({count, full, overflow, out} !== {3'd4, 1'b1, 1'b0, m_out}) begin
        failures++;
        $display("FAIL full_rw[%0d]: got count=%0d full=%b ovf=%b out=%h, expected 4 1 0 %h",
                 i, count, full, overflow, out, m_out);
      end
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 8'h00, 1'b0);
      checks++;
      if (out !== 8'h99 || out !== m_out) begin
        failures++;
        $display("FAIL wrap_drain[%0d]: got %h, expected 99", i, out);
      end
    end
    checks++;
    if (empty !== 1'b1) begin
      failures++;
      $display("FAIL wrap_empty: got %b, expected 1", empty);
    end
  endtask

  task automatic test_async_reset();
    cycle(1'b1, 1'b0, 8'hC1, 1'b0);
    cycle(1'b1, 1'b0, 8'hC2, 1'b0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({count, empty, out} !== {3'd0, 1'b1, 8'h00}) begin
      failures++;
      $display("FAIL async_rst: got count=%0d empty=%b out=%h, expected 0 1 00", count, empty, out);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    cycle(1'b1, 1'b0, 8'h77, 1'b0);
    cycle(1'b0, 1'b1, 8'h00, 1'b0);
    checks++;
    if ({out, count} !== {8'h77, 3'd0} || out !== m_out) begin
      failures++;
      $display("FAIL post_rst_read: got out=%h count=%0d, expected 77 0", out, count);
    end
  endtask
`else
  task automatic test_btn();
    in = 8'hB6;
    wr = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (count !== 3'd0) begin
        failures++;
        $display("FAIL btn_wr_hold[%0d]: got count=%0d, expected 0", i, count);
      end
    end
    wr = 1'b0;
    @(negedge clk);
    checks++;
    if (count !== 3'd0) begin
      failures++;
      $display("FAIL btn_wr_lat1: got count=%0d, expected 0", count);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (count !== 3'd1) begin
        failures++;
        $display("FAIL btn_wr_once[%0d]: got count=%0d, expected 1", i, count);
      end
    end
    in = 8'h00;
    rd = 1'b1;
    repeat (10) @(negedge clk);
    rd = 1'b0;
    @(negedge clk);
    checks++;
    if ({count, out} !== {3'd1, 8'h00}) begin
      failures++;
      $display("FAIL btn_rd_lat1: got count=%0d out=%h, expected 1 00", count, out);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({count, out, underflow} !== {3'd0, 8'hB6, 1'b0}) begin
        failures++;
        $display("FAIL btn_rd_once[%0d]: got count=%0d out=%h unf=%b, expected 0 b6 0", i, count, out, underflow);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
`ifndef FIFO_BTN_EDGE_EN
    test_fill();
    test_overflow_drain();
    test_underflow();
    test_full_concurrent();
    test_async_reset();
`else
    test_btn();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
